jt900h_intctl: RTL
==================

# jt900h_intctl

Programmable interrupt controller that sits directly upstream of the jt900h CPU core. It collects eight peripheral interrupt sources, latches and prioritises them, and drives the CPU `intrq[2:0]` level input. The CPU configures it and acknowledges interrupts through memory-mapped registers decoded from the CPU bus (`addr`, `dout`, `we`).

## Interface
Parameters:
- `BASE`, 24'h000080, byte address of the register block; must be 16-byte aligned.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high, one clock, sampled on `clk` rising edge
- `cen`  in  1  clock enable; all state advances only when high
- `irq_src`  in  8  peripheral interrupt requests, synchronous to `clk`
- `bus_addr`  in  24  CPU byte address
- `bus_din`  in  16  CPU write data
- `bus_we`  in  2  CPU byte write enables; [0] low byte, [1] high byte
- `bus_dout`  out  16  register read data, 0 when not hit
- `bus_hit`  out  1  `bus_addr` decodes to this block
- `intrq`  out  3  requested interrupt level to CPU; 0 = none

## Operation
- Decode: hit when `bus_addr[23:4]==BASE[23:4]`; register selected by `bus_addr[3:1]`. Reads are combinational. Writes take effect on `clk` when `cen` is high, using byte enables. Unmapped offsets read 0 and ignore writes.
- Register map (word offsets):
  - +0 PEND: [7:0] pending. Writing 1 clears the bit, edge mode only.
  - +2 MODE: [7:0], 1 = edge-triggered, 0 = level.
  - +4 PRIO0: 3-bit level of sources 0..3 in [2:0], [6:4], [10:8], [14:12].
  - +6 PRIO1: same layout for sources 4..7.
  - +8 STAT: read-only. [2:0] current `intrq`, [6:4] winning source index, [7] any enabled pending.
- Edge detect: `prev` register holds `irq_src` from the previous `cen` cycle. Edge source: pending sets on `irq_src & ~prev`.
- Level source: pending equals the registered `irq_src` and ignores clear writes.
- Set and clear in the same cycle: set wins.
- Priority level 0 disables a source. Its pending bit still latches but never contributes.
- Arbitration: among pending sources with a nonzero level, the highest level wins. Ties go to the lowest index.
- `intrq` is registered from the arbitration result. Level 7 is passed through unchanged (non-maskable in the CPU).
- MODE change from edge to level: pending immediately follows the source. Change from level to edge: the current pending value is held until cleared.

## Timing
- Reset values: PEND, MODE, PRIO0/1, `prev`, `intrq` all 0. `bus_dout`=0, `bus_hit` follows address only.
- Source rises and is sampled in `cen` cycle N: pending=1 after N. `intrq` is valid after N+1. Latency is 2 `cen` cycles.
- Clear write in cycle M: pending=0 after M, and `intrq` drops or re-arbitrates after M+1.
- Priority write in cycle M: new `intrq` after M+1.
- `cen` low: no state changes; writes are ignored.
- Reset mid-operation: all pending state is lost and `intrq` is 0 in the next cycle.

## Structure
- Shared package `jt900h_pkg`:
  - register offsets (PEND, MODE, PRIO0, PRIO1, STAT)
  - source count 8, level width 3
  - STAT field positions
- Sub-module `jt900h_intctl_prio`: combinational 8-way arbiter taking the pending vector and the 24-bit packed levels, returning winning level, index and any. It is reused for STAT and `intrq`.
- Top holds decode, registers, edge detect and output register.

## Test plan
- Reset then read all offsets: every read is 0, `intrq`=0. Read at `BASE+10` gives `bus_hit`=1, data 0.
- PRIO0=16'h0003, MODE=1, pulse `irq_src[0]` for 1 cycle: PEND=1 after 1 `cen` cycle, `intrq`=3 one cycle later. Write PEND=1: `intrq`=0 two cycles later.
- Sources 2 (level 5) and 6 (level 5) both in edge mode, both pulse: `intrq`=5, STAT[6:4]=2. Clear bit 2: STAT[6:4]=6, `intrq` stays 5.
- Level-mode source 4 at level 7 held high: clear writes have no effect. Drop the source: `intrq`=0 two cycles later.
- Pulse on a source at level 0: PEND bit set, `intrq`=0, STAT[7]=0. Then program level 2: `intrq`=2.
- Edge pulse coincident with clear of the same bit: the bit stays set. With `cen` low for 4 cycles, nothing changes.

Source files
------------

// File: rtl/jt900h_pkg.sv
// Shared constants for the jt900h interrupt controller: register offsets,
// source/level sizing and STAT field positions.
package jt900h_pkg;

    localparam int NSRC = 8;
    localparam int LVW  = 3;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MODE  = 3'd1;
    localparam logic [2:0] REG_PRIO0 = 3'd2;
    localparam logic [2:0] REG_PRIO1 = 3'd3;
    localparam logic [2:0] REG_STAT  = 3'd4;

    localparam int STAT_LEV_LSB = 0;
    localparam int STAT_IDX_LSB = 4;
    localparam int STAT_ANY_BIT = 7;

    // Spread four 3-bit levels into the nibble-aligned PRIOx read layout
    function automatic logic [15:0] pack_prio(input logic [4*LVW-1:0] lev4);
        pack_prio = {1'b0, lev4[11:9], 1'b0, lev4[8:6], 1'b0, lev4[5:3], 1'b0, lev4[2:0]};
    endfunction

endpackage

// File: rtl/jt900h_intctl_prio.sv
// Combinational 8-way priority arbiter: highest nonzero level among pending
// sources wins, ties resolved towards the lowest source index.
module jt900h_intctl_prio
    import jt900h_pkg::*;
(
    input  logic [NSRC-1:0]     pend,
    input  logic [NSRC*LVW-1:0] levels,
    output logic [LVW-1:0]      win_lev,
    output logic [2:0]          win_idx,
    output logic                any
);

    // Strict greater-than keeps the earlier (lower) index on ties and never lets level 0 win
    always_comb begin
        win_lev = 3'd0;
        win_idx = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && (levels[i*LVW +: LVW] > win_lev)) begin
                win_lev = levels[i*LVW +: LVW];
                win_idx = 3'(i);
            end else begin
                win_idx = win_idx;
            end
        end
        any = (win_lev != 3'd0);
    end

endmodule

// File: rtl/jt900h_intctl.sv
// Programmable 8-source interrupt controller feeding the jt900h intrq input:
// register decode, pending/edge logic and the registered interrupt level.
module jt900h_intctl
    import jt900h_pkg::*;
#(
    parameter logic [23:0] BASE = 24'h000080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  irq_src,
    input  logic [23:0] bus_addr,
    input  logic [15:0] bus_din,
    input  logic [1:0]  bus_we,
    output logic [15:0] bus_dout,
    output logic        bus_hit,
    output logic [2:0]  intrq
);

    logic [NSRC-1:0]     pend_r;
    logic [NSRC-1:0]     mode_r;
    logic [NSRC-1:0]     prev_r;
    logic [NSRC*LVW-1:0] lev_r;
    logic [2:0]          intrq_r;

    logic [NSRC-1:0]     pend_nxt_s;
    logic [NSRC-1:0]     mode_nxt_s;
    logic [NSRC*LVW-1:0] lev_nxt_s;
    logic [NSRC-1:0]     clr_s;
    logic [2:0]          reg_s;
    logic [LVW-1:0]      win_lev_s;
    logic [2:0]          win_idx_s;
    logic                win_any_s;
    logic [15:0]         rd_s;
    logic                unused_s;

    assign bus_hit  = (bus_addr[23:4] == BASE[23:4]);
    assign reg_s    = bus_addr[3:1];
    assign intrq    = intrq_r;
    assign unused_s = ^{bus_addr[0], bus_din[15], bus_din[11]};

    jt900h_intctl_prio u_prio (
        .pend    (pend_r),
        .levels  (lev_r),
        .win_lev (win_lev_s),
        .win_idx (win_idx_s),
        .any     (win_any_s)
    );

    // Register write decode and next-state of the pending vector
    always_comb begin
        mode_nxt_s = mode_r;
        lev_nxt_s  = lev_r;
        clr_s      = 8'h00;
        if (cen && bus_hit) begin
            case (reg_s)
                REG_PEND:  clr_s      = bus_we[0] ? bus_din[7:0] : 8'h00;
                REG_MODE:  mode_nxt_s = bus_we[0] ? bus_din[7:0] : mode_r;
                REG_PRIO0: begin
                    for (int j = 0; j < 4; j++) begin
                        lev_nxt_s[j*LVW +: LVW] = bus_we[j/2] ? bus_din[j*4 +: LVW] : lev_r[j*LVW +: LVW];
                    end
                end
                REG_PRIO1: begin
                    for (int j = 0; j < 4; j++) begin
                        lev_nxt_s[(j+4)*LVW +: LVW] = bus_we[j/2] ? bus_din[j*4 +: LVW] : lev_r[(j+4)*LVW +: LVW];
                    end
                end
                default: clr_s = 8'h00;
            endcase
        end else begin
            clr_s = 8'h00;
        end
        // The mode being written this cycle already governs pending, so a switch to level follows the source at once
        pend_nxt_s = (mode_nxt_s & ((pend_r & ~clr_s) | (irq_src & ~prev_r)))
                   | (~mode_nxt_s & irq_src);
    end

    // Controller state; everything freezes while cen is low
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r  <= 8'h00;
            mode_r  <= 8'h00;
            prev_r  <= 8'h00;
            lev_r   <= 24'h000000;
            intrq_r <= 3'd0;
        end else if (cen) begin
            pend_r  <= pend_nxt_s;
            mode_r  <= mode_nxt_s;
            prev_r  <= irq_src;
            lev_r   <= lev_nxt_s;
            intrq_r <= win_lev_s;
        end
    end

    // Combinational register read mux
    always_comb begin
        rd_s = 16'h0000;
        case (reg_s)
            REG_PEND:  rd_s = {8'h00, pend_r};
            REG_MODE:  rd_s = {8'h00, mode_r};
            REG_PRIO0: rd_s = pack_prio(lev_r[11:0]);
            REG_PRIO1: rd_s = pack_prio(lev_r[23:12]);
            REG_STAT: begin
                rd_s[STAT_LEV_LSB +: 3] = intrq_r;
                rd_s[STAT_IDX_LSB +: 3] = win_idx_s;
                rd_s[STAT_ANY_BIT]      = win_any_s;
            end
            default: rd_s = 16'h0000;
        endcase
        bus_dout = bus_hit ? rd_s : 16'h0000;
    end

endmodule
